// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Bits rippled per pipeline stage for the default configuration
    localparam int CHUNK = DEFAULT_WIDTH / DEFAULT_STAGES;

    // Bits rippled per pipeline stage for an arbitrary configuration
    function automatic int chunkWidth(input int width, input int stages);
        return width / stages;
    endfunction

    // Two's-complement overflow: the carry into the MSB disagrees with the carry out of it
    function automatic logic signedOverflow(input logic carryIntoMsb, input logic carryOutOfMsb);
        return carryIntoMsb ^ carryOutOfMsb;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// C-bit ripple-carry adder built from per-bit sum/carry equations.
// Also exposes the carry entering its top bit so the final chunk can flag signed overflow.
module adder_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic carry;

    // Ripple the carry from bit 0 upwards, capturing it just before the top bit
    always_comb begin
        carry    = cin;
        sum      = '0;
        c_msb_in = cin;
        for (int i = 0; i < C; i++) begin
            if (i == C - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides.
// Each stage ripples one CW-bit chunk in front of its register, so stage k's register
// holds the finished low (k+1)*CW sum bits, the carry out of chunk k and whatever
// operand bits are still to be added. The last stage's register is the output.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunkWidth(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gBadParams
        $error("pipelined_ripple_adder: WIDTH (%0d) must be a multiple of STAGES (%0d) with 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    logic [WIDTH-1:0]  bEff;
    logic [STAGES-1:0] validVec;
    logic [STAGES-1:0] readyVec;
    logic              chainFull;

    // Subtraction is a + ~b + 1; the inversion happens once, before the first stage
    assign bEff = sub ? ~b : b;

    // A slot may load when it, or any slot downstream of it, is empty, or the consumer takes the output
    always_comb begin
        readyVec  = '0;
        chainFull = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chainFull   = chainFull & validVec[k];
            readyVec[k] = out_ready | ~chainFull;
        end
    end

    assign in_ready = readyVec[0];

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int LO   = k * CW;
        localparam int DONE = (k + 1) * CW;
        localparam int UPW  = WIDTH - LO;

        logic [UPW-1:0]  upA;
        logic [UPW-1:0]  upB;
        logic            upValid;
        logic            chunkCin;
        logic [CW-1:0]   chunkSum;
        logic            chunkCout;
        logic            chunkCmsb;
        logic [DONE-1:0] sum_d;
        logic [DONE-1:0] sum_q;
        logic            valid_q;
        logic            carry_q;

        if (k == 0) begin : gHead
            assign upA      = a;
            assign upB      = bEff;
            assign chunkCin = sub ? 1'b1 : cin;
            assign upValid  = in_valid;
            assign sum_d    = chunkSum;
        end else begin : gBody
            assign upA      = gStage[k-1].gOps.a_q;
            assign upB      = gStage[k-1].gOps.b_q;
            assign chunkCin = gStage[k-1].carry_q;
            assign upValid  = gStage[k-1].valid_q;
            assign sum_d    = {chunkSum, gStage[k-1].sum_q};
        end

        adder_chunk #(
            .C(CW)
        ) uChunk (
            .a       (upA[CW-1:0]),
            .b       (upB[CW-1:0]),
            .cin     (chunkCin),
            .sum     (chunkSum),
            .cout    (chunkCout),
            .c_msb_in(chunkCmsb)
        );

        // Valid bit follows upstream whenever this slot may load, which squeezes bubbles out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else if (readyVec[k]) begin
                valid_q <= upValid;
            end
        end

        // Partial sum and chunk carry move only with a real beat, so a stalled result stays put
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (readyVec[k] && upValid) begin
                sum_q   <= sum_d;
                carry_q <= chunkCout;
            end
        end

        assign validVec[k] = valid_q;

        if (k < STAGES - 1) begin : gOps
            localparam int REM = WIDTH - DONE;

            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic           unusedCmsb;

            assign a_d        = upA[UPW-1:CW];
            assign b_d        = upB[UPW-1:CW];
            assign unusedCmsb = chunkCmsb;

            // Operand bits not yet added travel with the beat to the next stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (readyVec[k] && upValid) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : gTail
            logic cmsb_q;

            // The carry into the top result bit is kept for the overflow flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (readyVec[k] && upValid) begin
                    cmsb_q <= chunkCmsb;
                end
            end
        end
    end

    assign out_valid = gStage[STAGES-1].valid_q;
    assign sum       = gStage[STAGES-1].sum_q;
    assign cout      = gStage[STAGES-1].carry_q;
    assign ovf       = signedOverflow(gStage[STAGES-1].gTail.cmsb_q, gStage[STAGES-1].carry_q);

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard testbench: drivers push expected results when a beat is accepted,
// monitors pop and compare whenever a result is consumed.
module tb_pipelined_ripple_adder;

    typedef struct packed {
        logic [15:0] sumV;
        logic        coutV;
        logic        ovfV;
    } exp16_t;

    typedef struct packed {
        logic [7:0] sumV;
        logic       coutV;
        logic       ovfV;
    } exp8_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        sub8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    exp16_t      expQ[$];
    exp8_t       expQ8[$];
    int          passCount = 0;
    int          checkCount = 0;
    int          popCount = 0;

    pipelined_ripple_adder #(
        .WIDTH (16),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    pipelined_ripple_adder #(
        .WIDTH (8),
        .STAGES(1)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
        .sub      (sub8),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .sum      (sum8),
        .cout     (cout8),
        .ovf      (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat
    task automatic applyStimulus(input logic [15:0] aV, input logic [15:0] bV, input logic cinV,
                                 input logic subV, input logic [15:0] expSum, input logic expCout,
                                 input logic expOvf);
        int waitCycles = 0;
        a        = aV;
        b        = bV;
        cin      = cinV;
        sub      = subV;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
        end else begin
            expQ.push_back('{sumV: expSum, coutV: expCout, ovfV: expOvf});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus8(input logic [7:0] aV, input logic [7:0] bV, input logic cinV,
                                  input logic subV, input logic [7:0] expSum, input logic expCout,
                                  input logic expOvf);
        int waitCycles = 0;
        a8        = aV;
        b8        = bV;
        cin8      = cinV;
        sub8      = subV;
        in_valid8 = 1'b1;
        @(negedge clk);
        while (!in_ready8 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready8) begin
            checkOutput("in_ready8_wait", 32'(in_ready8), 32'd1);
        end else begin
            expQ8.push_back('{sumV: expSum, coutV: expCout, ovfV: expOvf});
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || expQ8.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", 32'(expQ.size() + expQ8.size()), 32'd0);
    endtask

    // Independent arithmetic reference for the 8-bit instance
    function automatic exp8_t model8(input logic [7:0] aV, input logic [7:0] bV, input logic cinV,
                                     input logic subV);
        logic [7:0] bE;
        logic [8:0] full;
        exp8_t      r;
        bE      = subV ? ~bV : bV;
        full    = {1'b0, aV} + {1'b0, bE} + {8'd0, (subV ? 1'b1 : cinV)};
        r.sumV  = full[7:0];
        r.coutV = full[8];
        r.ovfV  = (aV[7] == bE[7]) && (full[7] != aV[7]);
        return r;
    endfunction

    // Compare every consumed 16-bit result against the oldest expected one
    always @(negedge clk) begin
        exp16_t e;
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                popCount++;
                checkOutput("result16", 32'({sum, cout, ovf}), 32'({e.sumV, e.coutV, e.ovfV}));
            end
        end
    end

    // Compare every consumed 8-bit result against the oldest expected one
    always @(negedge clk) begin
        exp8_t e;
        if (rst_n && out_valid8 && out_ready8) begin
            if (expQ8.size() == 0) begin
                checkOutput("unexpected_result8", 32'(out_valid8), 32'd0);
            end else begin
                e = expQ8.pop_front();
                checkOutput("result8", 32'({sum8, cout8, ovf8}), 32'({e.sumV, e.coutV, e.ovfV}));
            end
        end
    end

    initial begin
        int lat;
        int seen;
        int popsBefore;
        int sent;
        int cycles;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        sub8       = 1'b0;
        out_ready8 = 1'b1;

        #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_outputs", 32'({sum, cout, ovf}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // First beat: latency and single-cycle presentation
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        checkOutput("latency16", 32'(lat), 32'd4);
        @(negedge clk);
        checkOutput("out_valid_one_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Carry ripple, overflow and subtraction, back to back
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        waitDrain();
        @(posedge clk);
        #1;

        // Backpressure: fill the pipe, check the stall, then release
        popsBefore = popCount;
        out_ready  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("in_ready_full", 32'(in_ready), 32'd0);
        checkOutput("out_valid_stalled", 32'(out_valid), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("sum_held", 32'(sum), 32'h0002);
            checkOutput("in_ready_held_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int i = 5; i <= 8; i++) begin
            applyStimulus(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0);
        end
        waitDrain();
        checkOutput("backpressure_result_count", 32'(popCount - popsBefore), 32'd8);
        @(posedge clk);
        #1;

        // Reset mid-flight: three beats held in the pipe, then an asynchronous pulse
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h0001, 1'b0, 1'b0, 16'h1112, 1'b0, 1'b0);
        applyStimulus(16'h2222, 16'h0002, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0);
        applyStimulus(16'h3333, 16'h0003, 1'b0, 1'b0, 16'h3336, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset_outputs", 32'({sum, cout, ovf}), 32'd0);
        expQ.delete();
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("no_stale_after_reset", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Single-stage 8-bit instance: directed vectors
        applyStimulus8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid8 && lat < 20);
        checkOutput("latency8", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        applyStimulus8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        applyStimulus8(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        waitDrain();
        @(posedge clk);
        #1;

        // Single-stage instance: random traffic with random consumer stalls
        sent   = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            ra         = 8'($urandom);
            rb         = 8'($urandom);
            rc         = 1'($urandom_range(0, 1));
            rs         = 1'($urandom_range(0, 1));
            a8         = ra;
            b8         = rb;
            cin8       = rc;
            sub8       = rs;
            in_valid8  = ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid8 && in_ready8) begin
                expQ8.push_back(model8(ra, rb, rc, rs));
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        checkOutput("random_beats_sent", 32'(sent), 32'd1000);
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
